// File: rtl/pwm_ramp_pkg.sv
// Shared types and arithmetic for the pwm ramp sequencer: FSM states, per-channel record, ramp step.
// WL_W is the wave-length/pulse-width width; the sequencer's WAVE_LEN_WIDTH must equal it.
package pwm_ramp_pkg;

  localparam int WL_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [WL_W-1:0] wl;
    logic [WL_W-1:0] cur;
    logic [WL_W-1:0] tgt;
    logic [WL_W-1:0] step;
  } ch_rec_t;

  function automatic logic [WL_W-1:0] wl_min(input logic [WL_W-1:0] a, input logic [WL_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // One ramp step toward tgt; the extra sum bit keeps an overshoot from wrapping below tgt.
  function automatic logic [WL_W-1:0] ramp_step(input logic [WL_W-1:0] cur,
                                                input logic [WL_W-1:0] tgt,
                                                input logic [WL_W-1:0] step);
    logic [WL_W:0]   sum;
    logic [WL_W-1:0] diff;
    logic [WL_W-1:0] res;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = cur - tgt;
    res  = cur;
    if (cur < tgt) begin
      res = (sum >= {1'b0, tgt}) ? tgt : sum[WL_W-1:0];
    end else if (cur > tgt) begin
      res = (diff <= step) ? tgt : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_ramp_tick.sv
// Ramp tick divider: free-running counter that raises a pending flag once per TICK_DIV cycles.
// A wrap while the flag is still set is dropped; a wrap coinciding with clr keeps the new tick.
module pwm_ramp_tick #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic pending
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pending <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Time-multiplexed pulse-width ramp controller for a bank of NUM_CH pwm instances.
// Optional sticky per-channel done status with done_clr when PWM_RAMP_DONE_STATUS_EN is defined.
//
// state | meaning
// IDLE  | waiting; accepts a command (priority) or starts a scan on a pending tick
// APPLY | accepted command's new values on outputs with its update strobe (or cmd_err)
// SCAN  | steps one channel per cycle, index 0..NUM_CH-1
// DRAIN | presents the last scanned channel's strobe before returning to IDLE
module pwm_ramp_sequencer
  import pwm_ramp_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int WAVE_LEN_WIDTH = WL_W,
  parameter int TICK_DIV       = 1024,
  parameter int CH_WIDTH       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [CH_WIDTH-1:0]                cmd_ch,
  input  logic [WAVE_LEN_WIDTH-1:0]          cmd_wave_length,
  input  logic [WAVE_LEN_WIDTH-1:0]          cmd_target,
  input  logic [WAVE_LEN_WIDTH-1:0]          cmd_step,
  output logic                               cmd_err,
  output logic [NUM_CH-1:0]                  pwm_update,
  output logic [NUM_CH*WAVE_LEN_WIDTH-1:0]   pwm_wave_length,
  output logic [NUM_CH*WAVE_LEN_WIDTH-1:0]   pwm_pulse_width,
`ifdef PWM_RAMP_DONE_STATUS_EN
  output logic [NUM_CH-1:0]                  done,
  input  logic [NUM_CH-1:0]                  done_clr,
`endif
  output logic [NUM_CH-1:0]                  busy
);

  localparam logic [CH_WIDTH:0]   NUM_CH_L = (CH_WIDTH + 1)'(NUM_CH);
  localparam logic [CH_WIDTH-1:0] LAST_CH  = CH_WIDTH'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [CH_WIDTH-1:0] scan_idx_q;
  logic                scan_start;
  logic                tick_pending;
  logic                cmd_ok;
  logic [WL_W-1:0]     eff_tgt;
  logic [WL_W-1:0]     nxt_cur;
  ch_rec_t             ch_q [NUM_CH];
  ch_rec_t             ch_d [NUM_CH];
  logic [NUM_CH-1:0]   upd_d;
  logic                err_d;
`ifdef PWM_RAMP_DONE_STATUS_EN
  logic [NUM_CH-1:0]   done_set;
`endif

  pwm_ramp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clr     (scan_start),
    .pending (tick_pending)
  );

  assign cmd_ok  = (cmd_wave_length != '0) && ({1'b0, cmd_ch} < NUM_CH_L);
  assign eff_tgt = wl_min(cmd_target, cmd_wave_length);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    scan_start = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = APPLY;
        end else if (tick_pending) begin
          state_d    = SCAN;
          scan_start = 1'b1;
        end
      end
      APPLY:   state_d = IDLE;
      SCAN:    if (scan_idx_q == LAST_CH) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel registers change at the accept/scan edge so the strobe cycle already shows the new values.
  always_comb begin
    ch_d    = ch_q;
    upd_d   = '0;
    err_d   = 1'b0;
    nxt_cur = '0;
`ifdef PWM_RAMP_DONE_STATUS_EN
    done_set = '0;
`endif
    if (state_q == IDLE && cmd_valid) begin
      if (!cmd_ok) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cmd_ch == CH_WIDTH'(i)) begin
            ch_d[i].wl   = cmd_wave_length;
            ch_d[i].tgt  = eff_tgt;
            ch_d[i].step = cmd_step;
            ch_d[i].cur  = (cmd_step == '0) ? eff_tgt : wl_min(ch_q[i].cur, cmd_wave_length);
            upd_d[i]     = 1'b1;
`ifdef PWM_RAMP_DONE_STATUS_EN
            done_set[i]  = (cmd_step == '0);
`endif
          end
        end
      end
    end else if (state_q == SCAN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (scan_idx_q == CH_WIDTH'(i)) begin
          nxt_cur = ramp_step(ch_q[i].cur, ch_q[i].tgt, ch_q[i].step);
          if (nxt_cur != ch_q[i].cur) begin
            ch_d[i].cur = nxt_cur;
            upd_d[i]    = 1'b1;
`ifdef PWM_RAMP_DONE_STATUS_EN
            done_set[i] = (nxt_cur == ch_q[i].tgt);
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= '0;
      end
      pwm_update <= '0;
      cmd_err    <= 1'b0;
      scan_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= ch_d[i];
      end
      pwm_update <= upd_d;
      cmd_err    <= err_d;
      if (scan_start) begin
        scan_idx_q <= '0;
      end else if (state_q == SCAN) begin
        scan_idx_q <= scan_idx_q + 1'b1;
      end
    end
  end

`ifdef PWM_RAMP_DONE_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= '0;
    end else begin
      done <= (done & ~done_clr) | done_set;
    end
  end
`endif

  always_comb begin
    pwm_wave_length = '0;
    pwm_pulse_width = '0;
    busy            = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_wave_length[i*WAVE_LEN_WIDTH +: WAVE_LEN_WIDTH] = ch_q[i].wl;
      pwm_pulse_width[i*WAVE_LEN_WIDTH +: WAVE_LEN_WIDTH] = ch_q[i].cur;
      busy[i] = (ch_q[i].cur != ch_q[i].tgt);
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: directed commands push hand-computed strobe/error events,
// a negedge monitor pops and compares them whenever the DUT strobes pwm_update or cmd_err.
module tb_pwm_ramp_sequencer;

  localparam int NCH  = 3;
  localparam int W    = 11;
  localparam int CHW  = 2;
  localparam int TDIV = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [CHW-1:0]      cmd_ch = '0;
  logic [W-1:0]        cmd_wave_length = '0;
  logic [W-1:0]        cmd_target = '0;
  logic [W-1:0]        cmd_step = '0;
  logic                cmd_err;
  logic [NCH-1:0]      pwm_update;
  logic [NCH*W-1:0]    pwm_wave_length;
  logic [NCH*W-1:0]    pwm_pulse_width;
  logic [NCH-1:0]      busy;
`ifdef PWM_RAMP_DONE_STATUS_EN
  logic [NCH-1:0]      done;
  logic [NCH-1:0]      done_clr = '0;
`endif

  pwm_ramp_sequencer #(
    .NUM_CH(NCH), .WAVE_LEN_WIDTH(W), .TICK_DIV(TDIV), .CH_WIDTH(CHW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_ch          (cmd_ch),
    .cmd_wave_length (cmd_wave_length),
    .cmd_target      (cmd_target),
    .cmd_step        (cmd_step),
    .cmd_err         (cmd_err),
    .pwm_update      (pwm_update),
    .pwm_wave_length (pwm_wave_length),
    .pwm_pulse_width (pwm_pulse_width),
`ifdef PWM_RAMP_DONE_STATUS_EN
    .done            (done),
    .done_clr        (done_clr),
`endif
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int ch;
    int wl;
    int pw;
    bit busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_upd [NCH];
  exp_t e;
  int   aw, ap;

  initial for (int i = 0; i < NCH; i++) last_upd[i] = -10;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push_upd(input int ch, input int wl, input int pw, input bit b);
    exp_t x;
    x.is_err = 1'b0; x.ch = ch; x.wl = wl; x.pw = pw; x.busy = b;
    q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1; x.ch = 0; x.wl = 0; x.pw = 0; x.busy = 1'b0;
    q.push_back(x);
  endtask

  // Monitor: every strobe or error pulse consumes one expected event.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        if (pwm_update[i]) begin
          n_cmp++;
          if (cyc - last_upd[i] < 2) begin
            n_err++;
            $display("FAIL strobe_gap ch%0d: previous strobe cycle %0d, this cycle %0d, need gap >= 2",
                     i, last_upd[i], cyc);
          end
          last_upd[i] = cyc;
          aw = int'(pwm_wave_length[i*W +: W]);
          ap = int'(pwm_pulse_width[i*W +: W]);
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_update: ch%0d wl=%0d pw=%0d busy=%0d, expected no event",
                     i, aw, ap, busy[i]);
          end else begin
            e = q.pop_front();
            if (e.is_err || e.ch != i || e.wl != aw || e.pw != ap || e.busy != busy[i]) begin
              n_err++;
              $display("FAIL update_event: got upd ch%0d wl=%0d pw=%0d busy=%0d, expected err=%0d ch%0d wl=%0d pw=%0d busy=%0d",
                       i, aw, ap, busy[i], e.is_err, e.ch, e.wl, e.pw, e.busy);
            end
          end
        end
      end
      if (cmd_err) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_err: got cmd_err=1, expected no event");
        end else begin
          e = q.pop_front();
          if (!e.is_err) begin
            n_err++;
            $display("FAIL err_event: got cmd_err, expected upd ch%0d wl=%0d pw=%0d", e.ch, e.wl, e.pw);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input int ch, input int wl, input int tgt, input int step);
    int n;
    logic [31:0] v_ch, v_wl, v_tg, v_st;
    v_ch = ch; v_wl = wl; v_tg = tgt; v_st = step;
    cmd_valid       = 1'b1;
    cmd_ch          = v_ch[CHW-1:0];
    cmd_wave_length = v_wl[W-1:0];
    cmd_target      = v_tg[W-1:0];
    cmd_step        = v_st[W-1:0];
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending_events"}, q.size(), 0);
  endtask

  // Returns at the negedge of the first SCAN cycle (cmd_ready drops with no command in flight).
  task automatic wait_scan();
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    while (cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL scan_timeout: no scan seen within %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_update", int'(pwm_update), 0);
    chk("reset_wave_length", int'(pwm_wave_length), 0);
    chk("reset_pulse_width", int'(pwm_pulse_width), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cmd_err", int'(cmd_err), 0);

    // step 0 jumps straight to target
    push_upd(0, 100, 50, 1'b0);
    send_cmd(0, 100, 50, 0);
    wait_drain("ch0_jump");

    // ramp up 0 -> 16 -> 32 -> 40
    push_upd(1, 100, 0, 1'b1);
    push_upd(1, 100, 16, 1'b1);
    push_upd(1, 100, 32, 1'b1);
    push_upd(1, 100, 40, 1'b0);
    send_cmd(1, 100, 40, 16);
    wait_drain("ch1_ramp_up");

    // ramp down 90 -> 60 -> 30 -> 5 without underflow
    push_upd(2, 100, 90, 1'b0);
    send_cmd(2, 100, 90, 0);
    push_upd(2, 100, 90, 1'b1);
    push_upd(2, 100, 60, 1'b1);
    push_upd(2, 100, 30, 1'b1);
    push_upd(2, 100, 5, 1'b0);
    send_cmd(2, 100, 5, 30);
    wait_drain("ch2_ramp_down");

    // rejected commands leave channel state untouched
    push_err();
    send_cmd(0, 0, 30, 0);
    push_err();
    send_cmd(NCH, 100, 30, 0);
    wait_drain("reject");
    chk("reject_ch0_wl", int'(pwm_wave_length[0 +: W]), 100);
    chk("reject_ch0_pw", int'(pwm_pulse_width[0 +: W]), 50);

    // target above wave length clamps to wave length
    push_upd(0, 100, 100, 1'b0);
    send_cmd(0, 100, 200, 0);
    wait_drain("clamp");

    // last channel: scan strobe in DRAIN, then a command held during SCAN
    push_upd(2, 100, 5, 1'b1);
    push_upd(2, 100, 35, 1'b0);
    send_cmd(2, 100, 35, 30);
    wait_scan();
    push_upd(2, 100, 0, 1'b0);
    send_cmd(2, 100, 0, 0);
    wait_drain("after_scan_cmd");

    // retarget mid-ramp: 40 -> 60 upward, then down toward 10 with step 25
    push_upd(1, 100, 40, 1'b1);
    push_upd(1, 100, 60, 1'b1);
    send_cmd(1, 100, 100, 20);
    wait_drain("retarget_up");
    push_upd(1, 100, 60, 1'b1);
    push_upd(1, 100, 35, 1'b1);
    push_upd(1, 100, 10, 1'b0);
    send_cmd(1, 100, 10, 25);
    wait_drain("retarget_down");

    // reset in the first SCAN cycle of a ch0 ramp-down
    push_upd(0, 100, 100, 1'b1);
    send_cmd(0, 100, 0, 10);
    wait_scan();
    #2 reset = 1'b1;
    #1;
    chk("midscan_update", int'(pwm_update), 0);
    chk("midscan_wave_length", int'(pwm_wave_length), 0);
    chk("midscan_pulse_width", int'(pwm_pulse_width), 0);
    chk("midscan_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);
    repeat (40) @(negedge clk);
    chk("post_reset_pulse_width", int'(pwm_pulse_width), 0);
    chk("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
